// File: rtl/midi_pkg.sv
// Shared MIDI constants, message codes and status encoding used by the tx and rx paths.
package midi_pkg;

  localparam int unsigned MIDI_CLKS_PER_BIT = 1600;
  localparam int unsigned BYTE_W            = 8;
  localparam int unsigned DATA_W            = 7;
  localparam int unsigned CH_W              = 4;
  localparam int unsigned BIT_CNT_W         = 4;

  localparam logic [1:0] MT_NOTE_OFF = 2'b00;
  localparam logic [1:0] MT_NOTE_ON  = 2'b01;
  localparam logic [1:0] MT_PROG_CHG = 2'b10;
  localparam logic [1:0] MT_RESERVED = 2'b11;

  localparam logic [3:0] SN_NOTE_OFF = 4'h8;
  localparam logic [3:0] SN_NOTE_ON  = 4'h9;
  localparam logic [3:0] SN_PROG_CHG = 4'hC;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_STATUS = 2'd1,
    S_DATA1  = 2'd2,
    S_DATA2  = 2'd3
  } tx_state_e;

  // 0x00 for the reserved type: never a valid status byte
  function automatic logic [BYTE_W-1:0] status_byte(input logic [1:0] mt,
                                                    input logic [CH_W-1:0] ch);
    logic [BYTE_W-1:0] s;
    s = 8'h00;
    case (mt)
      MT_NOTE_OFF: s = {SN_NOTE_OFF, ch};
      MT_NOTE_ON:  s = {SN_NOTE_ON, ch};
      MT_PROG_CHG: s = {SN_PROG_CHG, ch};
      default:     s = 8'h00;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/midi_tx_uart.sv
// 8N1 serializer; a new START is taken in the last stop-bit cycle so frames run back-to-back.
module uart_tx
  import midi_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = MIDI_CLKS_PER_BIT
) (
  input  logic              CLK,
  input  logic              CE,
  input  logic              RST,
  input  logic [BYTE_W-1:0] DI,
  input  logic              START,
  output logic              BUSY,
  output logic              DO
);

  localparam int unsigned TMR_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(CLKS_PER_BIT - 1);
  localparam logic [BIT_CNT_W-1:0] BIT_STOP = BIT_CNT_W'(9);

  logic                 r_busy;
  logic [TMR_W-1:0]     r_timer;
  logic [BIT_CNT_W-1:0] r_bit;
  logic [BYTE_W:0]      r_shift;
  logic                 r_do;
  logic                 w_bit_end;
  logic                 w_frame_end;
  logic                 w_load;

  assign w_bit_end   = r_busy && (r_timer == TMR_LAST);
  assign w_frame_end = w_bit_end && (r_bit == BIT_STOP);
  assign BUSY        = r_busy && !w_frame_end;
  assign w_load      = CE && START && !BUSY;
  assign DO          = r_do;

  // Shift register is filled with ones so the stop bit falls out after the 8 data bits
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_busy  <= 1'b0;
      r_timer <= '0;
      r_bit   <= '0;
      r_shift <= '1;
      r_do    <= 1'b1;
    end else if (w_load) begin
      r_busy  <= 1'b1;
      r_timer <= '0;
      r_bit   <= '0;
      r_shift <= {1'b1, DI};
      r_do    <= 1'b0;
    end else if (CE && r_busy) begin
      if (w_bit_end) begin
        r_timer <= '0;
        if (w_frame_end) begin
          r_busy <= 1'b0;
          r_bit  <= '0;
          r_do   <= 1'b1;
        end else begin
          r_bit   <= r_bit + BIT_CNT_W'(1);
          r_do    <= r_shift[0];
          r_shift <= {1'b1, r_shift[BYTE_W:1]};
        end
      end else begin
        r_timer <= r_timer + TMR_W'(1);
      end
    end
  end

endmodule

// File: rtl/midi_tx.sv
// MIDI channel-voice transmitter: message FSM with running status, feeding the uart_tx serializer.
module midi_tx
  import midi_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT   = MIDI_CLKS_PER_BIT,
  parameter int unsigned RUNNING_STATUS = 1
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              CE,
  input  logic              REQ,
  input  logic [1:0]        MSG_TYPE,
  input  logic [CH_W-1:0]   CHANNEL,
  input  logic [DATA_W-1:0] DATA1,
  input  logic [DATA_W-1:0] DATA2,
  output logic              READY,
  output logic              DO
);

  tx_state_e         r_state;
  tx_state_e         w_state_nxt;
  logic              r_prog;
  logic [DATA_W-1:0] r_d1;
  logic [DATA_W-1:0] r_d2;
  logic [BYTE_W-1:0] r_last_status;

  logic [BYTE_W-1:0] w_status_in;
  logic              w_accept;
  logic              w_rs_hit;
  logic              w_busy;
  logic              w_adv;
  logic              w_start;
  logic [BYTE_W-1:0] w_byte;

  assign w_status_in = status_byte(MSG_TYPE, CHANNEL);
  assign w_accept    = CE && REQ && (r_state == S_IDLE) && (MSG_TYPE != MT_RESERVED);
  assign w_rs_hit    = (RUNNING_STATUS != 0) && (w_status_in == r_last_status);
  assign w_adv       = CE && !w_busy;
  assign READY       = (r_state == S_IDLE);

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:   if (w_accept) w_state_nxt = w_rs_hit ? S_DATA1 : S_STATUS;
      S_STATUS: if (w_adv) w_state_nxt = S_DATA1;
      S_DATA1:  if (w_adv) w_state_nxt = r_prog ? S_IDLE : S_DATA2;
      S_DATA2:  if (w_adv) w_state_nxt = S_IDLE;
      default:  w_state_nxt = S_IDLE;
    endcase
  end

  // The first byte comes straight from the request so its start bit begins the next cycle
  always_comb begin
    w_start = 1'b0;
    w_byte  = '0;
    case (r_state)
      S_IDLE: if (w_accept) begin
        w_start = 1'b1;
        w_byte  = w_rs_hit ? {1'b0, DATA1} : w_status_in;
      end
      S_STATUS: if (w_adv) begin
        w_start = 1'b1;
        w_byte  = {1'b0, r_d1};
      end
      S_DATA1: if (w_adv && !r_prog) begin
        w_start = 1'b1;
        w_byte  = {1'b0, r_d2};
      end
      default: ;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_prog        <= 1'b0;
      r_d1          <= '0;
      r_d2          <= '0;
      r_last_status <= 8'h00;
    end else if (w_accept) begin
      r_prog <= (MSG_TYPE == MT_PROG_CHG);
      r_d1   <= DATA1;
      r_d2   <= DATA2;
      if (!w_rs_hit) r_last_status <= w_status_in;
    end
  end

  uart_tx #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_uart_tx (
    .CLK  (CLK),
    .CE   (CE),
    .RST  (RST),
    .DI   (w_byte),
    .START(w_start),
    .BUSY (w_busy),
    .DO   (DO)
  );

endmodule

// File: tb/tb_midi_tx.sv
// Scoreboard bench for midi_tx: one running-status and one always-status instance, serial decoder on both lines.
module tb_midi_tx;

  localparam int unsigned CPB = 4;
  localparam int unsigned FRAME = 10 * CPB;

  logic       CLK = 1'b0;
  logic       RST;
  logic       CE;
  logic       REQ;
  logic [1:0] MSG_TYPE;
  logic [3:0] CHANNEL;
  logic [6:0] DATA1;
  logic [6:0] DATA2;
  logic       rdy0, rdy1, do0, do1;

  int n_checks = 0;
  int n_errors = 0;

  logic [7:0] q0[$];
  logic [7:0] q1[$];
  logic [7:0] last0;

  logic       m_act[2];
  int         m_cnt[2];
  logic [7:0] m_sh[2];

  always #5 CLK = ~CLK;

  midi_tx #(.CLKS_PER_BIT(CPB), .RUNNING_STATUS(1)) u_rs (
    .CLK(CLK), .RST(RST), .CE(CE), .REQ(REQ), .MSG_TYPE(MSG_TYPE), .CHANNEL(CHANNEL),
    .DATA1(DATA1), .DATA2(DATA2), .READY(rdy0), .DO(do0));

  midi_tx #(.CLKS_PER_BIT(CPB), .RUNNING_STATUS(0)) u_nrs (
    .CLK(CLK), .RST(RST), .CE(CE), .REQ(REQ), .MSG_TYPE(MSG_TYPE), .CHANNEL(CHANNEL),
    .DATA1(DATA1), .DATA2(DATA2), .READY(rdy1), .DO(do1));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference encoding of a request into the two expected byte streams
  task automatic push_msg(input logic [1:0] mt, input logic [3:0] ch, input logic [6:0] d1,
                          input logic [6:0] d2, output int nb0, output int nb1);
    logic [7:0] st;
    nb0 = 0;
    nb1 = 0;
    if (mt == 2'b11) return;
    st = (mt == 2'b00) ? {4'h8, ch} : (mt == 2'b01) ? {4'h9, ch} : {4'hC, ch};
    if (st != last0) begin q0.push_back(st); nb0++; last0 = st; end
    q1.push_back(st); nb1++;
    q0.push_back({1'b0, d1}); nb0++;
    q1.push_back({1'b0, d1}); nb1++;
    if (mt != 2'b10) begin
      q0.push_back({1'b0, d2}); nb0++;
      q1.push_back({1'b0, d2}); nb1++;
    end
  endtask

  task automatic mon_step(input int k, input logic d);
    int off;
    logic [7:0] exp_b;
    if (!m_act[k]) begin
      if (d == 1'b0) begin m_act[k] = 1'b1; m_cnt[k] = 1; end
    end else begin
      off = m_cnt[k];
      if ((off % CPB) == 2 && off >= 6 && off <= 34) m_sh[k][(off - 6) / CPB] = d;
      if (off == 38) begin
        chk(k == 0 ? "stop0" : "stop1", {31'd0, d}, 32'd1);
        if (k == 0) begin
          chk("extra0", {31'd0, q0.size() > 0}, 32'd1);
          if (q0.size() > 0) begin exp_b = q0.pop_front(); chk("byte0", {24'd0, m_sh[k]}, {24'd0, exp_b}); end
        end else begin
          chk("extra1", {31'd0, q1.size() > 0}, 32'd1);
          if (q1.size() > 0) begin exp_b = q1.pop_front(); chk("byte1", {24'd0, m_sh[k]}, {24'd0, exp_b}); end
        end
        m_act[k] = 1'b0;
      end
      m_cnt[k] = off + 1;
    end
  endtask

  always @(negedge CLK) begin
    if (RST) begin
      m_act[0] = 1'b0;
      m_act[1] = 1'b0;
    end else if (CE) begin
      mon_step(0, do0);
      mon_step(1, do1);
    end
  end

  task automatic wait_ready();
    bit ok;
    ok = 0;
    for (int i = 0; i < 5000 && !ok; i++) begin
      @(negedge CLK);
      if (rdy0 && rdy1) ok = 1;
    end
    if (!ok) chk("ready_timeout", 32'd0, 32'd1);
  endtask

  task automatic issue(input logic [1:0] mt, input logic [3:0] ch, input logic [6:0] d1,
                       input logic [6:0] d2, output int nb0, output int nb1);
    wait_ready();
    @(posedge CLK); #1;
    MSG_TYPE = mt; CHANNEL = ch; DATA1 = d1; DATA2 = d2; REQ = 1'b1; CE = 1'b1;
    push_msg(mt, ch, d1, d2, nb0, nb1);
    @(posedge CLK); #1;
    REQ = 1'b0;
  endtask

  task automatic send(input logic [1:0] mt, input logic [3:0] ch, input logic [6:0] d1,
                      input logic [6:0] d2, input bit tgl, input bit pulse);
    int nb0, nb1, c0, c1, mul;
    bit done;
    issue(mt, ch, d1, d2, nb0, nb1);
    c0 = 0; c1 = 0; done = 0;
    mul = tgl ? 2 : 1;
    for (int i = 0; i < 3000 && !done; i++) begin
      CE = tgl ? ~CE : 1'b1;
      if (pulse && i == 50) begin REQ = 1'b1; MSG_TYPE = 2'b10; DATA1 = 7'h7F; end
      else REQ = 1'b0;
      @(negedge CLK);
      if (!rdy0) c0++;
      if (!rdy1) c1++;
      if (rdy0 && rdy1) done = 1;
      else begin @(posedge CLK); #1; end
    end
    CE = 1'b1;
    REQ = 1'b0;
    chk("msg_done", {31'd0, done}, 32'd1);
    chk("ready_low0", c0, nb0 * FRAME * mul);
    chk("ready_low1", c1, nb1 * FRAME * mul);
    chk("drain0", q0.size(), 32'd0);
    chk("drain1", q1.size(), 32'd0);
  endtask

  initial begin
    int nb0, nb1;
    RST = 1'b1; CE = 1'b1; REQ = 1'b0;
    MSG_TYPE = 2'b00; CHANNEL = 4'd0; DATA1 = 7'd0; DATA2 = 7'd0;
    last0 = 8'h00;
    m_act[0] = 1'b0; m_act[1] = 1'b0; m_cnt[0] = 0; m_cnt[1] = 0;
    repeat (3) @(posedge CLK);
    #1;
    chk("rst_do0", {31'd0, do0}, 32'd1);
    chk("rst_rdy0", {31'd0, rdy0}, 32'd1);
    chk("rst_do1", {31'd0, do1}, 32'd1);
    RST = 1'b0;
    @(negedge CLK);
    chk("post_rst_rdy1", {31'd0, rdy1}, 32'd1);

    send(2'b01, 4'd0, 7'h3C, 7'h64, 0, 0);
    send(2'b01, 4'd0, 7'h3C, 7'h40, 0, 0);
    send(2'b10, 4'd2, 7'h05, 7'h00, 0, 0);
    send(2'b00, 4'd2, 7'h3C, 7'h40, 0, 0);
    send(2'b11, 4'd0, 7'h11, 7'h22, 0, 0);
    send(2'b01, 4'd1, 7'h11, 7'h22, 0, 1);

    // Abort mid second byte; status must be resent afterwards
    issue(2'b01, 4'd0, 7'h3C, 7'h64, nb0, nb1);
    repeat (60) @(posedge CLK);
    #2;
    RST = 1'b1;
    #1;
    chk("abort_do0", {31'd0, do0}, 32'd1);
    chk("abort_do1", {31'd0, do1}, 32'd1);
    chk("abort_rdy0", {31'd0, rdy0}, 32'd1);
    chk("abort_rdy1", {31'd0, rdy1}, 32'd1);
    chk("abort_left0", q0.size(), 32'd2);
    q0.delete();
    q1.delete();
    last0 = 8'h00;
    @(posedge CLK); #1;
    RST = 1'b0;
    send(2'b01, 4'd0, 7'h3C, 7'h64, 0, 0);

    send(2'b00, 4'd15, 7'h10, 7'h00, 1, 0);

    repeat (2 * FRAME) @(posedge CLK);
    chk("final_q0", q0.size(), 32'd0);
    chk("final_q1", q1.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/midi_tx.md
Name: midi_tx

Overview:
- Transmit-side counterpart of the MIDI receive path (uart_rx + midi parser).
- Accepts one channel-voice message request (Note Off, Note On, Program Change), encodes it to MIDI bytes, and serializes them as 8N1 UART frames on a single output line.
- Used to echo or forward synth events to external MIDI gear, and as a stimulus source for the receive path in loopback tests.

Parameters:
- CLKS_PER_BIT, 1600, number of CE-qualified CLK cycles per serial bit (50 MHz / 31250 baud).
- RUNNING_STATUS, 1, 1 = omit the status byte when it equals the last transmitted status; 0 = always send it.

Ports:
- CLK  input  1  system clock.
- RST  input  1  asynchronous active-high reset.
- CE  input  1  clock enable; when 0, all state, counters and outputs hold.
- REQ  input  1  message request, qualified by READY and CE.
- MSG_TYPE  input  2  00 = Note Off, 01 = Note On, 10 = Program Change, 11 = reserved.
- CHANNEL  input  4  MIDI channel 0-15.
- DATA1  input  7  note number, or program number.
- DATA2  input  7  velocity; ignored for Program Change.
- READY  output  1  high when a new request can be accepted.
- DO  output  1  serial MIDI line; idle high.

Behaviour:
- Reset (async, RST=1):
  - DO=1, READY=1, FSM in IDLE, bit counter and bit timer cleared.
  - Stored last status cleared to 0x00 (an invalid status, so the next message always sends its status byte).
- Accept rule:
  - A request is accepted on a CLK edge where CE=1, READY=1 and REQ=1.
  - MSG_TYPE, CHANNEL, DATA1 and DATA2 are registered on that edge; READY=0 from the next cycle.
  - REQ while READY=0 is ignored; no queuing.
- Reserved type: MSG_TYPE=11 is never accepted. READY stays 1 and no bytes are sent.
- Encoding:
  - Status byte: 0x80|CHANNEL (Note Off), 0x90|CHANNEL (Note On), 0xC0|CHANNEL (Program Change).
  - Data bytes are {1'b0, DATAn}; bit 7 is always 0.
- Byte count:
  - Note On/Off: status, DATA1, DATA2.
  - Program Change: status, DATA1.
  - With RUNNING_STATUS=1, the status byte is skipped when it equals the stored last status.
  - The stored last status is updated whenever a status byte is sent.
- FSM states: IDLE -> STATUS -> DATA1 -> DATA2 -> IDLE.
  - STATUS is bypassed on a running-status hit.
  - DATA2 is bypassed for Program Change.
  - Each non-IDLE state issues one byte to the serializer and advances when its stop bit completes.
- Frame format:
  - Start bit 0, then 8 data bits LSB first, then stop bit 1.
  - Each bit lasts exactly CLKS_PER_BIT CE cycles.
  - One frame = 10*CLKS_PER_BIT CE cycles.
- Timing:
  - DO drives the first start bit on the cycle after acceptance.
  - Consecutive bytes of one message are back-to-back: the next start bit immediately follows the previous stop bit, with no idle gap.
  - READY returns to 1 in the cycle after the last stop bit period ends.
  - A new request accepted on that cycle starts its start bit on the following cycle.
- CE=0: bit timer, FSM and DO hold their values; timing stretches accordingly.
- Reset mid-frame: DO returns to 1 immediately (asynchronously); the partial frame is abandoned; running status is cleared.
- Bit timer width: clog2(CLKS_PER_BIT). Bit counter: 4 bits, counting 0-9.

Decomposition:
- Shared package midi_pkg:
  - Message type codes (MT_NOTE_OFF=2'b00, MT_NOTE_ON=2'b01, MT_PROG_CHG=2'b10).
  - Status nibbles 4'h8, 4'h9, 4'hC.
  - Default MIDI CLKS_PER_BIT constant.
  - Also consumed by the midi parser.
- Sub-module uart_tx:
  - Ports CLK, CE, RST, DI[7:0], START, BUSY, DO.
  - Handles framing and bit timing.
  - midi_tx keeps only the message FSM and running-status register.

Test Plan (CLKS_PER_BIT=4):
- Note On, ch 0, DATA1=0x3C, DATA2=0x64 after reset -> DO carries 0x90, 0x3C, 0x64 back-to-back; READY low for exactly 120 CE cycles.
- Same Note On repeated with DATA2=0x40, RUNNING_STATUS=1 -> bytes 0x3C, 0x40 only (80 cycles). With RUNNING_STATUS=0 -> 0x90, 0x3C, 0x40.
- Program Change, ch 2, DATA1=0x05 -> bytes 0xC2, 0x05 (80 cycles). A following Note Off on ch 2 sends status 0x82.
- REQ pulsed during transmission, and MSG_TYPE=11 while idle -> neither produces extra bytes; the in-flight byte sequence is unchanged.
- RST asserted mid-way through the second byte -> DO=1 immediately, READY=1. The next identical Note On resends status 0x90.
- CE toggled 1/0 every cycle during a Note Off ch 15 (0x8F, 0x10, 0x00) -> correct bytes; total duration 240 CLK cycles.
